// File: rtl/store_queue.sv
// Post-commit store buffer: in-order drain to the data-memory write port and
// youngest-match store-to-load forwarding over all occupied entries.
package store_queue_pkg;
  localparam int STORE_QUEUE_SIZE = 64;
  localparam int ADDR_WIDTH       = 26;
  localparam int DATA_WIDTH       = 32;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } opt_memory_write_t;
endpackage

module store_queue
  import store_queue_pkg::*;
#(
  parameter int DEPTH = STORE_QUEUE_SIZE,
  parameter int AW    = ADDR_WIDTH,
  parameter int DW    = DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [AW-1:0]            enq_addr,
  input  logic [DW-1:0]            enq_data,
  output opt_memory_write_t        mem_write,
  input  logic                     mem_ready,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  output logic                     fwd_hit,
  output logic [DW-1:0]            fwd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          enq_fire;
  logic          deq_fire;
  logic [PW-1:0] scan_idx;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign enq_ready = !full;
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = !empty && mem_ready;

  // Entry contents are masked while empty so stale data never reaches memory.
  assign mem_write.valid = !empty;
  assign mem_write.addr  = empty ? '0 : ADDR_WIDTH'(addr_mem[head]);
  assign mem_write.data  = empty ? '0 : DATA_WIDTH'(data_mem[head]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) tail <= tail + 1'b1;
      if (deq_fire) head <= head + 1'b1;
      if (enq_fire && !deq_fire)      count <= count + 1'b1;
      else if (deq_fire && !enq_fire) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      addr_mem[tail] <= enq_addr;
      data_mem[tail] <= enq_data;
    end
  end

  // Walk oldest to youngest so the last match found is the youngest store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    scan_idx = '0;
    if (ld_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        scan_idx = head + PW'(i);
        if ((CW'(i) < count) && (addr_mem[scan_idx] == ld_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = data_mem[scan_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: vector table for single-cycle behaviour plus
// hand sequences for fill/wrap, concurrent enqueue/dequeue and async reset.
module tb_store_queue;
  import store_queue_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              enq_valid;
  logic              enq_ready;
  logic [25:0]       enq_addr;
  logic [31:0]       enq_data;
  opt_memory_write_t mem_write;
  logic              mem_ready;
  logic              ld_valid;
  logic [25:0]       ld_addr;
  logic              fwd_hit;
  logic [31:0]       fwd_data;
  logic [6:0]        count;
  logic              full;
  logic              empty;

  int checks = 0;
  int errors = 0;

  store_queue dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_addr(enq_addr), .enq_data(enq_data),
    .mem_write(mem_write), .mem_ready(mem_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        enq_v;
    logic [25:0] enq_a;
    logic [31:0] enq_d;
    logic        mr;
    logic        ld_v;
    logic [25:0] ld_a;
    logic [6:0]  e_count;
    logic        e_mv;
    logic [25:0] e_ma;
    logic [31:0] e_md;
    logic        e_hit;
    logic [31:0] e_fwd;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mkv(logic ev, logic [25:0] ea, logic [31:0] ed, logic mr,
                               logic lv, logic [25:0] la, logic [6:0] c, logic mv,
                               logic [25:0] ma, logic [31:0] md, logic h, logic [31:0] fd);
    vec_t v;
    v.enq_v = ev; v.enq_a = ea; v.enq_d = ed; v.mr = mr; v.ld_v = lv; v.ld_a = la;
    v.e_count = c; v.e_mv = mv; v.e_ma = ma; v.e_md = md; v.e_hit = h; v.e_fwd = fd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic [25:0] ea, input logic [31:0] ed,
                       input logic mr, input logic lv, input logic [25:0] la);
    @(negedge clk);
    enq_valid = ev; enq_addr = ea; enq_data = ed;
    mem_ready = mr; ld_valid = lv; ld_addr = la;
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_enq_ready"}, 32'(enq_ready), 32'd1);
    chk({tag, "_mv"}, 32'(mem_write.valid), 32'd0);
    chk({tag, "_ma"}, 32'(mem_write.addr), 32'd0);
    chk({tag, "_md"}, mem_write.data, 32'd0);
    chk({tag, "_hit"}, 32'(fwd_hit), 32'd0);
    chk({tag, "_fwd"}, fwd_data, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_q[$];
    int nxt, got, cyc, over;

    vecs[0]  = mkv(0, 26'h00, 32'h0,        0, 0, 26'h00, 0, 0, 26'h00, 32'h0,        0, 32'h0);
    vecs[1]  = mkv(1, 26'h10, 32'hDEADBEEF, 0, 1, 26'h10, 0, 0, 26'h00, 32'h0,        0, 32'h0);
    vecs[2]  = mkv(0, 26'h00, 32'h0,        0, 1, 26'h10, 1, 1, 26'h10, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    vecs[3]  = mkv(0, 26'h00, 32'h0,        0, 1, 26'h10, 1, 1, 26'h10, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    vecs[4]  = mkv(0, 26'h00, 32'h0,        0, 1, 26'h10, 1, 1, 26'h10, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    vecs[5]  = mkv(0, 26'h00, 32'h0,        1, 1, 26'h10, 1, 1, 26'h10, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    vecs[6]  = mkv(0, 26'h00, 32'h0,        0, 1, 26'h10, 0, 0, 26'h00, 32'h0,        0, 32'h0);
    vecs[7]  = mkv(1, 26'h20, 32'h1,        0, 0, 26'h00, 0, 0, 26'h00, 32'h0,        0, 32'h0);
    vecs[8]  = mkv(1, 26'h24, 32'h2,        0, 0, 26'h00, 1, 1, 26'h20, 32'h1,        0, 32'h0);
    vecs[9]  = mkv(1, 26'h20, 32'h3,        0, 1, 26'h20, 2, 1, 26'h20, 32'h1,        1, 32'h1);
    vecs[10] = mkv(0, 26'h00, 32'h0,        0, 1, 26'h20, 3, 1, 26'h20, 32'h1,        1, 32'h3);
    vecs[11] = mkv(0, 26'h00, 32'h0,        0, 1, 26'h28, 3, 1, 26'h20, 32'h1,        0, 32'h0);
    vecs[12] = mkv(0, 26'h00, 32'h0,        0, 1, 26'h24, 3, 1, 26'h20, 32'h1,        1, 32'h2);
    vecs[13] = mkv(1, 26'h34, 32'h9,        1, 1, 26'h34, 3, 1, 26'h20, 32'h1,        0, 32'h0);
    vecs[14] = mkv(0, 26'h00, 32'h0,        1, 1, 26'h34, 3, 1, 26'h24, 32'h2,        1, 32'h9);
    vecs[15] = mkv(0, 26'h00, 32'h0,        1, 1, 26'h20, 2, 1, 26'h20, 32'h3,        1, 32'h3);
    vecs[16] = mkv(0, 26'h00, 32'h0,        1, 1, 26'h20, 1, 1, 26'h34, 32'h9,        0, 32'h0);
    vecs[17] = mkv(0, 26'h00, 32'h0,        1, 0, 26'h34, 0, 0, 26'h00, 32'h0,        0, 32'h0);
    vecs[18] = mkv(1, 26'h30, 32'h7,        1, 0, 26'h00, 0, 0, 26'h00, 32'h0,        0, 32'h0);
    vecs[19] = mkv(0, 26'h00, 32'h0,        1, 1, 26'h30, 1, 1, 26'h30, 32'h7,        1, 32'h7);
    vecs[20] = mkv(0, 26'h00, 32'h0,        0, 1, 26'h30, 0, 0, 26'h00, 32'h0,        0, 32'h0);

    rst = 1'b1; enq_valid = 0; enq_addr = '0; enq_data = '0;
    mem_ready = 0; ld_valid = 0; ld_addr = '0;
    repeat (2) @(negedge clk);
    #1 chk_reset_outputs("init_rst");
    rst = 1'b0;

    for (int k = 0; k < 21; k++) begin
      drive(vecs[k].enq_v, vecs[k].enq_a, vecs[k].enq_d, vecs[k].mr, vecs[k].ld_v, vecs[k].ld_a);
      chk($sformatf("v%0d_count", k), 32'(count), 32'(vecs[k].e_count));
      chk($sformatf("v%0d_empty", k), 32'(empty), 32'(vecs[k].e_count == 0));
      chk($sformatf("v%0d_full", k), 32'(full), 32'd0);
      chk($sformatf("v%0d_enq_ready", k), 32'(enq_ready), 32'd1);
      chk($sformatf("v%0d_mv", k), 32'(mem_write.valid), 32'(vecs[k].e_mv));
      chk($sformatf("v%0d_ma", k), 32'(mem_write.addr), 32'(vecs[k].e_ma));
      chk($sformatf("v%0d_md", k), mem_write.data, vecs[k].e_md);
      chk($sformatf("v%0d_hit", k), 32'(fwd_hit), 32'(vecs[k].e_hit));
      chk($sformatf("v%0d_fwd", k), fwd_data, vecs[k].e_fwd);
    end

    // Fill to capacity, then offer a 65th store that must be dropped.
    for (int i = 0; i < 64; i++) begin
      drive(1, 26'h100 + 26'(i), 32'(i), 0, 0, 26'h0);
      exp_q.push_back(32'(i));
    end
    drive(1, 26'h3FF, 32'hBAD, 0, 0, 26'h0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_enq_ready", 32'(enq_ready), 32'd0);
    chk("fill_count", 32'(count), 32'd64);
    drive(0, 26'h0, 32'h0, 0, 0, 26'h0);
    chk("fill_count_after_drop", 32'(count), 32'd64);

    for (int i = 100; i <= 163; i++) exp_q.push_back(32'(i));
    nxt = 100; got = 0; cyc = 0; over = 0;
    while (got < 128 && cyc < 400) begin
      drive(nxt <= 163, 26'h200 + 26'(nxt), 32'(nxt), 1, 0, 26'h0);
      if (count > 7'd64) over++;
      if (cyc == 1) begin
        chk("reopen_count", 32'(count), 32'd63);
        chk("reopen_enq_ready", 32'(enq_ready), 32'd1);
      end
      if (mem_write.valid) begin
        chk($sformatf("drain_%0d", got), mem_write.data, exp_q.pop_front());
        got++;
      end
      if (enq_valid && enq_ready) nxt++;
      cyc++;
    end
    chk("drain_all_received", 32'(got), 32'd128);
    chk("drain_no_overflow", 32'(over), 32'd0);
    drive(0, 26'h0, 32'h0, 0, 0, 26'h0);
    chk("drain_empty", 32'(empty), 32'd1);

    // Concurrent enqueue and dequeue hold occupancy steady at 5.
    for (int i = 0; i < 5; i++) drive(1, 26'h300 + 26'(i), 32'(200 + i), 0, 0, 26'h0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 26'h305 + 26'(k), 32'(205 + k), 1, 0, 26'h0);
      chk($sformatf("conc_count_%0d", k), 32'(count), 32'd5);
      chk($sformatf("conc_data_%0d", k), mem_write.data, 32'(200 + k));
    end
    for (int k = 3; k < 8; k++) begin
      drive(0, 26'h0, 32'h0, 1, 0, 26'h0);
      chk($sformatf("conc_data_%0d", k), mem_write.data, 32'(200 + k));
      chk($sformatf("conc_tail_count_%0d", k), 32'(count), 32'(8 - k));
    end
    drive(0, 26'h0, 32'h0, 0, 0, 26'h0);
    chk("conc_empty", 32'(empty), 32'd1);

    // Async reset between clock edges while draining ten entries.
    for (int i = 0; i < 10; i++) drive(1, 26'h400 + 26'(i), 32'h500 + 32'(i), 0, 0, 26'h0);
    drive(0, 26'h0, 32'h0, 1, 1, 26'h405);
    chk("pre_rst_hit", 32'(fwd_hit), 32'd1);
    chk("pre_rst_count", 32'(count), 32'd10);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0; mem_ready = 0; ld_valid = 0;
    #1;
    chk("post_rst_empty", 32'(empty), 32'd1);
    chk("post_rst_mv", 32'(mem_write.valid), 32'd0);
    drive(1, 26'h55, 32'h66, 0, 1, 26'h405);
    chk("post_rst_stale_hit", 32'(fwd_hit), 32'd0);
    drive(0, 26'h0, 32'h0, 0, 1, 26'h405);
    chk("post_rst_mv1", 32'(mem_write.valid), 32'd1);
    chk("post_rst_ma", 32'(mem_write.addr), 32'h55);
    chk("post_rst_md", mem_write.data, 32'h66);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_stale_hit2", 32'(fwd_hit), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
